// File: rtl/alsu_gen.sv
// alsu_gen: two-stage pipelined arithmetic/logic/shift unit.
// Stage 1 registers the whole input bundle; stage 2 computes the result from
// that one sample and registers out_o, leds_o and err_cnt_o.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   in_valid_i                   qualifies the input bundle this cycle
//   a_i, b_i [WIDTH-1:0]         operands
//   opcode_i [2:0]               operation select
//   cin_i, serial_in_i           carry-in, shift fill bit
//   direction_i                  shift/rotate direction (1 = left)
//   red_op_a_i, red_op_b_i       reduction selects (opcodes 000/001 only)
//   bypass_a_i, bypass_b_i       operand bypass, overrides everything
//   out_o [2*WIDTH-1:0]          registered result
//   out_valid_o                  out_o was updated by a valid bundle
//   leds_o [15:0]                toggles on each invalid operation
//   err_cnt_o [7:0]              saturating invalid-operation count
module alsu_gen #(
  parameter int unsigned WIDTH          = 3,
  parameter string       INPUT_PRIORITY = "A",
  parameter string       FULL_ADDER     = "ON"
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [2:0]           opcode_i,
  input  logic                 cin_i,
  input  logic                 serial_in_i,
  input  logic                 direction_i,
  input  logic                 red_op_a_i,
  input  logic                 red_op_b_i,
  input  logic                 bypass_a_i,
  input  logic                 bypass_b_i,
  output logic [2*WIDTH-1:0]   out_o,
  output logic                 out_valid_o,
  output logic [15:0]          leds_o,
  output logic [7:0]           err_cnt_o
);

  localparam bit PrioB  = (INPUT_PRIORITY == "B");
  localparam bit AddCin = (FULL_ADDER == "ON");
  localparam int unsigned OW = 2 * WIDTH;

  // Stage 1 sample
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [2:0]       s1_op_q;
  logic             s1_cin_q, s1_sin_q, s1_dir_q;
  logic             s1_red_a_q, s1_red_b_q, s1_byp_a_q, s1_byp_b_q;

  // Stage 2 state
  logic [OW-1:0] out_q, out_d;
  logic          out_valid_q;
  logic [15:0]   leds_q, leds_d;
  logic [7:0]    err_q, err_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_cin_q   <= 1'b0;
      s1_sin_q   <= 1'b0;
      s1_dir_q   <= 1'b0;
      s1_red_a_q <= 1'b0;
      s1_red_b_q <= 1'b0;
      s1_byp_a_q <= 1'b0;
      s1_byp_b_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid_i;
      s1_a_q     <= a_i;
      s1_b_q     <= b_i;
      s1_op_q    <= opcode_i;
      s1_cin_q   <= cin_i;
      s1_sin_q   <= serial_in_i;
      s1_dir_q   <= direction_i;
      s1_red_a_q <= red_op_a_i;
      s1_red_b_q <= red_op_b_i;
      s1_byp_a_q <= bypass_a_i;
      s1_byp_b_q <= bypass_b_i;
    end
  end

  logic             invalid;
  logic [WIDTH-1:0] byp_opnd, red_opnd;
  logic [WIDTH:0]   sum_w;
  logic [OW-1:0]    prod_w;

  always_comb begin
    // Reduction on opcodes other than 000/001 is illegal, as are 110/111.
    invalid  = (s1_op_q[2:1] == 2'b11) ||
               ((s1_red_a_q | s1_red_b_q) && (s1_op_q[2:1] != 2'b00));
    byp_opnd = (s1_byp_a_q && s1_byp_b_q) ? (PrioB ? s1_b_q : s1_a_q) :
               (s1_byp_a_q ? s1_a_q : s1_b_q);
    red_opnd = (s1_red_a_q && s1_red_b_q) ? (PrioB ? s1_b_q : s1_a_q) :
               (s1_red_a_q ? s1_a_q : s1_b_q);
    sum_w    = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, s1_cin_q & AddCin};
    prod_w   = {{WIDTH{1'b0}}, s1_a_q} * {{WIDTH{1'b0}}, s1_b_q};

    out_d  = out_q;
    leds_d = leds_q;
    err_d  = err_q;

    if (s1_valid_q) begin
      if (s1_byp_a_q || s1_byp_b_q) begin
        out_d  = {{WIDTH{1'b0}}, byp_opnd};
        leds_d = '0;
      end else if (invalid) begin
        out_d  = '0;
        leds_d = ~leds_q;
        if (err_q != 8'hff) err_d = err_q + 8'd1;
      end else begin
        leds_d = '0;
        case (s1_op_q)
          3'b000: out_d = (s1_red_a_q || s1_red_b_q) ? {{(OW-1){1'b0}}, &red_opnd} :
                                                       {{WIDTH{1'b0}}, s1_a_q & s1_b_q};
          3'b001: out_d = (s1_red_a_q || s1_red_b_q) ? {{(OW-1){1'b0}}, ^red_opnd} :
                                                       {{WIDTH{1'b0}}, s1_a_q ^ s1_b_q};
          3'b010: out_d = {{(WIDTH-1){1'b0}}, sum_w};
          3'b011: out_d = prod_w;
          3'b100: out_d = s1_dir_q ? {out_q[OW-2:0], s1_sin_q} : {s1_sin_q, out_q[OW-1:1]};
          3'b101: out_d = s1_dir_q ? {out_q[OW-2:0], out_q[OW-1]} : {out_q[0], out_q[OW-1:1]};
          default: out_d = out_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      leds_q      <= '0;
      err_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= s1_valid_q;
      leds_q      <= leds_d;
      err_q       <= err_d;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;
  assign leds_o      = leds_q;
  assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_alsu_gen.sv
// Self-checking bench for alsu_gen (WIDTH=3, INPUT_PRIORITY="B", FULL_ADDER="ON").
// A bundle-level model tracks the expected outputs every cycle; directed
// vectors carry hand-computed expectations as well.
module tb_alsu_gen;

  localparam int W      = 3;
  localparam bit PRIO_B = 1'b1;
  localparam bit FULL   = 1'b1;

  typedef struct packed {
    logic         v;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         cin, sin, dir, ra, rb, ba, bb;
  } bundle_t;

  typedef struct packed {
    logic [2*W-1:0] out;
    logic           ov;
    logic [15:0]    leds;
    logic [7:0]     err;
  } mstate_t;

  logic clk = 1'b0;
  logic rst;
  bundle_t drv, p1;
  mstate_t m;
  bit chk_en = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] out;
  logic           out_valid;
  logic [15:0]    leds;
  logic [7:0]     err_cnt;

  always #5 clk = ~clk;

  alsu_gen #(
    .WIDTH(W),
    .INPUT_PRIORITY("B"),
    .FULL_ADDER("ON")
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (drv.v),
    .a_i        (drv.a),
    .b_i        (drv.b),
    .opcode_i   (drv.op),
    .cin_i      (drv.cin),
    .serial_in_i(drv.sin),
    .direction_i(drv.dir),
    .red_op_a_i (drv.ra),
    .red_op_b_i (drv.rb),
    .bypass_a_i (drv.ba),
    .bypass_b_i (drv.bb),
    .out_o      (out),
    .out_valid_o(out_valid),
    .leds_o     (leds),
    .err_cnt_o  (err_cnt)
  );

  function automatic bundle_t mk(int op, int a, int b, bit cin = 0, bit sin = 0, bit dir = 0,
                                 bit ra = 0, bit rb = 0, bit ba = 0, bit bb = 0);
    bundle_t x;
    x.v = 1'b1; x.op = 3'(op); x.a = W'(a); x.b = W'(b);
    x.cin = cin; x.sin = sin; x.dir = dir; x.ra = ra; x.rb = rb; x.ba = ba; x.bb = bb;
    return x;
  endfunction

  // Idle bundle carries an illegal opcode so a stray update would show up.
  function automatic bundle_t idle();
    bundle_t x;
    x = mk(6, 5, 2);
    x.v = 1'b0;
    return x;
  endfunction

  // Outcome of one stage-1 sample, computed from the operation rules.
  function automatic mstate_t step(mstate_t s, bundle_t b);
    mstate_t n;
    int a, bv, o, sel, r, full, top;
    n = s; n.ov = b.v;
    if (!b.v) return n;
    a = int'(b.a); bv = int'(b.b); o = int'(s.out);
    full = 1 << (2 * W); top = 1 << (2 * W - 1);
    r = o;
    if (b.ba || b.bb) begin
      r = (b.ba && b.bb) ? (PRIO_B ? bv : a) : (b.ba ? a : bv);
      n.leds = '0;
    end else if (b.op >= 6 || ((b.ra || b.rb) && b.op >= 2)) begin
      r = 0;
      n.leds = ~s.leds;
      if (s.err != 8'd255) n.err = s.err + 8'd1;
    end else begin
      n.leds = '0;
      sel = (b.ra && b.rb) ? (PRIO_B ? bv : a) : (b.ra ? a : bv);
      case (b.op)
        3'd0: r = (b.ra || b.rb) ? ((sel == (1 << W) - 1) ? 1 : 0) : (a & bv);
        3'd1: r = (b.ra || b.rb) ? ($countones(sel) % 2) : (a ^ bv);
        3'd2: r = a + bv + ((FULL && b.cin) ? 1 : 0);
        3'd3: r = a * bv;
        3'd4: r = b.dir ? (o * 2 + int'(b.sin)) % full : int'(b.sin) * top + o / 2;
        3'd5: r = b.dir ? (o * 2) % full + o / top : (o % 2) * top + o / 2;
        default: r = o;
      endcase
    end
    n.out = (2*W)'(r);
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m  <= '0;
      p1 <= '0;
    end else begin
      m  <= step(m, p1);
      p1 <= drv;
    end
  end

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out", 16'(out), 16'(m.out));
      chk("model_out_valid", 16'(out_valid), 16'(m.ov));
      chk("model_leds", leds, m.leds);
      chk("model_err_cnt", 16'(err_cnt), 16'(m.err));
    end
  end

  task automatic send(bundle_t b);
    @(negedge clk);
    drv = b;
  endtask

  bundle_t        tab [14];
  logic [2*W-1:0] texp[14];

  initial begin
    drv = idle();
    rst = 1'b1;
    tab[0]  = mk(0, 6, 3);                             texp[0]  = 6'd2;
    tab[1]  = mk(1, 6, 3);                             texp[1]  = 6'd5;
    tab[2]  = mk(1, 7, 0, 0, 0, 0, 1);                 texp[2]  = 6'd1;
    tab[3]  = mk(0, 7, 2, 0, 0, 0, 1);                 texp[3]  = 6'd1;
    tab[4]  = mk(0, 7, 6, 0, 0, 0, 0, 1);              texp[4]  = 6'd0;
    tab[5]  = mk(2, 7, 7, 1);                          texp[5]  = 6'd15;
    tab[6]  = mk(3, 5, 0);                             texp[6]  = 6'd0;
    tab[7]  = mk(1, 5, 1, 0, 0, 0, 1, 1);              texp[7]  = 6'd1;
    tab[8]  = mk(7, 3, 3);                             texp[8]  = 6'd0;
    tab[9]  = mk(6, 1, 2, 0, 0, 0, 0, 0, 1, 1);        texp[9]  = 6'd2;
    tab[10] = mk(3, 4, 1, 0, 0, 0, 0, 0, 1, 0);        texp[10] = 6'd4;
    tab[11] = mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 1);        texp[11] = 6'd3;
    tab[12] = mk(4, 0, 0, 0, 1, 0);                    texp[12] = 6'd33;
    tab[13] = mk(5, 0, 0, 0, 0, 1);                    texp[13] = 6'd3;

    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) send(idle());
    chk("reset_out", 16'(out), 16'd0);
    chk("reset_out_valid", 16'(out_valid), 16'd0);
    chk("reset_leds", leds, 16'd0);
    chk("reset_err_cnt", 16'(err_cnt), 16'd0);

    // Add with carry, then full product
    send(mk(2, 5, 1, 1));
    send(idle());
    @(negedge clk);
    chk("add_5_1_cin", 16'(out), 16'd7);
    chk("add_out_valid", 16'(out_valid), 16'd1);
    send(mk(3, 7, 7));
    send(idle());
    @(negedge clk);
    chk("mul_7_7", 16'(out), 16'd49);

    // Back-to-back shift-left then rotate-right
    send(mk(4, 0, 0, 0, 1, 1));
    send(mk(5, 0, 0, 0, 0, 0));
    send(idle());
    chk("shl_sin1", 16'(out), 16'd35);
    @(negedge clk);
    chk("ror_back", 16'(out), 16'd49);

    // Three invalid ops toggle leds, then bypass both picks B
    repeat (3) send(mk(6, 2, 2));
    chk("inv1_leds", leds, 16'hffff);
    send(mk(0, 1, 6, 0, 0, 0, 0, 0, 1, 1));
    chk("inv2_leds", leds, 16'h0000);
    send(idle());
    chk("inv3_leds", leds, 16'hffff);
    chk("inv3_err", 16'(err_cnt), 16'd3);
    send(idle());
    chk("byp_both_out", 16'(out), 16'd6);
    chk("byp_both_leds", leds, 16'd0);
    chk("byp_both_err", 16'(err_cnt), 16'd3);

    // Both reduction flags: AND-reduce of B, then illegal with add
    send(mk(0, 7, 3, 0, 0, 0, 1, 1));
    send(mk(2, 7, 3, 0, 0, 0, 1, 1));
    send(idle());
    chk("red_and_b", 16'(out), 16'd0);
    @(negedge clk);
    chk("red_add_err", 16'(err_cnt), 16'd4);

    foreach (tab[i]) begin
      send(tab[i]);
      send(idle());
      send(idle());
      chk($sformatf("vec%0d", i), 16'(out), 16'(texp[i]));
    end

    // Reset one edge after a valid bundle discards it
    send(mk(0, 5, 0, 0, 0, 0, 0, 0, 1, 0));
    send(idle());
    send(idle());
    chk("pre_rst_out", 16'(out), 16'd5);
    send(mk(3, 7, 7));
    @(negedge clk);
    rst = 1'b1;
    drv = idle();
    @(negedge clk);
    chk("rst_inflight_valid", 16'(out_valid), 16'd0);
    chk("rst_inflight_out", 16'(out), 16'd0);
    rst = 1'b0;
    send(idle());
    chk("post_rst_valid", 16'(out_valid), 16'd0);
    send(mk(2, 1, 1));
    send(idle());
    chk("post_rst_valid_lat", 16'(out_valid), 16'd0);
    @(negedge clk);
    chk("post_rst_add", 16'(out), 16'd2);
    chk("post_rst_valid_hi", 16'(out_valid), 16'd1);

    // Saturation of the error counter
    repeat (260) send(mk(7, 0, 0));
    repeat (2) send(idle());
    chk("err_saturate", 16'(err_cnt), 16'd255);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
